// File: rtl/assoc_pkg.sv
// Shared definitions for the associative-search argmax stage: default sizes and FSM encoding.
package assoc_pkg;

    localparam int DEF_SCORE_W     = 7;
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } assoc_state_t;

endpackage

// File: rtl/assoc_max_cmp.sv
// Combinational best/runner-up update for one incoming class score.
module assoc_max_cmp #(
    parameter int SCORE_W = 7,
    parameter int IDX_W   = 4
) (
    input  logic               first,
    input  logic [SCORE_W-1:0] score,
    input  logic [IDX_W-1:0]   idx,
    input  logic [SCORE_W-1:0] best,
    input  logic [SCORE_W-1:0] second,
    input  logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_next,
    output logic [SCORE_W-1:0] second_next,
    output logic [IDX_W-1:0]   best_idx_next
);

    // Strict greater-than keeps the lower index on ties; the old best drops to runner-up.
    always_comb begin
        best_next     = best;
        second_next   = second;
        best_idx_next = best_idx;
        if (first) begin
            best_next     = score;
            second_next   = '0;
            best_idx_next = '0;
        end else if (score > best) begin
            second_next   = best;
            best_next     = score;
            best_idx_next = idx;
        end else if (score > second) begin
            second_next   = score;
        end
    end

endmodule

// File: rtl/assoc_argmax_seq.sv
// Final stage of the associative search: streams NUM_CLASSES scores and reports the
// winning class, its score and the margin to the runner-up.
module assoc_argmax_seq
    import assoc_pkg::*;
#(
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic [SCORE_W-1:0] score_in,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_score,
    output logic [SCORE_W-1:0] margin
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    assoc_state_t       state, state_next;
    logic [IDX_W-1:0]   count;
    logic [SCORE_W-1:0] second;
    logic [SCORE_W-1:0] best_next, second_next;
    logic [IDX_W-1:0]   best_idx_next;
    logic               accept, last_beat, enter_collect;

    assoc_max_cmp #(
        .SCORE_W(SCORE_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .first        (count == '0),
        .score        (score_in),
        .idx          (count),
        .best         (best_score),
        .second       (second),
        .best_idx     (best_idx),
        .best_next    (best_next),
        .second_next  (second_next),
        .best_idx_next(best_idx_next)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start is only looked at outside COLLECT, so a stray pulse mid-search is harmless.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        last_beat     = 1'b0;
        enter_collect = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = COLLECT;
                    enter_collect = 1'b1;
                end
            end
            COLLECT: begin
                accept    = score_valid;
                last_beat = score_valid && (count == LAST_IDX);
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next    = COLLECT;
                    enter_collect = 1'b1;
                end else begin
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign score_ready = (state == COLLECT);
    assign busy        = (state == COLLECT);
    assign done        = (state == DONE);

    // margin is taken from the post-update values so it lands together with the done cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            count      <= '0;
            best_score <= '0;
            second     <= '0;
            best_idx   <= '0;
            margin     <= '0;
        end else if (enter_collect) begin
            count      <= '0;
            best_score <= '0;
            second     <= '0;
            best_idx   <= '0;
        end else if (accept) begin
            count      <= count + IDX_W'(1);
            best_score <= best_next;
            second     <= second_next;
            best_idx   <= best_idx_next;
            if (last_beat) begin
                margin <= best_next - second_next;
            end
        end
    end

endmodule
